// File: rtl/bnn_layer_sequencer.sv
// Top-level scheduler for the BNN pipeline: steps LOAD -> LAYER_1..3 -> DONE,
// issues one-cycle layer resets, qualifies sticky done flags and runs a per-layer watchdog.
module bnn_layer_sequencer #(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        abort,
   input  logic        load_done,
   input  logic        l1_done,
   input  logic        l2_done,
   input  logic        l3_done,
   output logic [2:0]  state,
   output logic        l1_rst_n,
   output logic        l2_rst_n,
   output logic        l3_rst_n,
   output logic        busy,
   output logic        result_valid,
   output logic        timeout_err,
   output logic [15:0] cycle_count
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'b000,
      S_LOAD    = 3'b001,
      S_LAYER_1 = 3'b010,
      S_LAYER_2 = 3'b011,
      S_LAYER_3 = 3'b100,
      S_DONE    = 3'b101,
      S_ERROR   = 3'b110
   } state_t;

   localparam logic [15:0] PHASE_LIMIT = 16'(TIMEOUT_CYCLES - 1);

   state_t      cur, nxt;
   logic [15:0] phase, nxt_phase;
   logic [15:0] nxt_count;
   logic        cur_busy;

   // Done is trusted only from phase 2, after the phase-0 reset has cleared any stale flag.
   always_comb begin
      nxt       = cur;
      nxt_phase = 16'd0;
      nxt_count = cycle_count;
      cur_busy  = (cur == S_LOAD) || (cur == S_LAYER_1) ||
                  (cur == S_LAYER_2) || (cur == S_LAYER_3);

      if (cur_busy && (cycle_count != 16'hFFFF))
         nxt_count = cycle_count + 16'd1;

      if (abort) begin
         nxt = S_IDLE;
      end else begin
         case (cur)
            S_IDLE, S_DONE, S_ERROR: begin
               if (start) begin
                  nxt       = S_LOAD;
                  nxt_count = 16'd0;
               end
            end
            S_LOAD:    if (load_done) nxt = S_LAYER_1;
            S_LAYER_1: begin
               if (l1_done && (phase >= 16'd2)) nxt = S_LAYER_2;
               else if (phase == PHASE_LIMIT)   nxt = S_ERROR;
            end
            S_LAYER_2: begin
               if (l2_done && (phase >= 16'd2)) nxt = S_LAYER_3;
               else if (phase == PHASE_LIMIT)   nxt = S_ERROR;
            end
            S_LAYER_3: begin
               if (l3_done && (phase >= 16'd2)) nxt = S_DONE;
               else if (phase == PHASE_LIMIT)   nxt = S_ERROR;
            end
            default:   nxt = S_IDLE;
         endcase
      end

      if (nxt == cur)
         nxt_phase = (phase == 16'hFFFF) ? phase : phase + 16'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur          <= S_IDLE;
         phase        <= 16'd0;
         cycle_count  <= 16'd0;
         l1_rst_n     <= 1'b0;
         l2_rst_n     <= 1'b0;
         l3_rst_n     <= 1'b0;
         busy         <= 1'b0;
         result_valid <= 1'b0;
         timeout_err  <= 1'b0;
      end else begin
         cur          <= nxt;
         phase        <= nxt_phase;
         cycle_count  <= nxt_count;
         l1_rst_n     <= (nxt == S_LAYER_1) && (nxt_phase != 16'd0);
         l2_rst_n     <= (nxt == S_LAYER_2) && (nxt_phase != 16'd0);
         l3_rst_n     <= (nxt == S_LAYER_3) && (nxt_phase != 16'd0);
         busy         <= (nxt == S_LOAD) || (nxt == S_LAYER_1) ||
                         (nxt == S_LAYER_2) || (nxt == S_LAYER_3);
         result_valid <= (nxt == S_DONE);
         timeout_err  <= (nxt == S_ERROR);
      end
   end

   assign state = cur;

endmodule

// File: tb/tb_bnn_layer_sequencer.sv
// Scoreboard bench for bnn_layer_sequencer: expected state entries are queued by
// the stimulus and checked by a monitor on each observed state change.
module tb_bnn_layer_sequencer;

   localparam int T     = 300;
   localparam int NEVER = 1 << 20;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic        load_done = 1'b0;
   logic        l1_done = 1'b0;
   logic        l2_done = 1'b0;
   logic        l3_done = 1'b0;
   logic [2:0]  state;
   logic        l1_rst_n, l2_rst_n, l3_rst_n;
   logic        busy, result_valid, timeout_err;
   logic [15:0] cycle_count;

   bnn_layer_sequencer #(.TIMEOUT_CYCLES(T)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .load_done(load_done), .l1_done(l1_done), .l2_done(l2_done), .l3_done(l3_done),
      .state(state), .l1_rst_n(l1_rst_n), .l2_rst_n(l2_rst_n), .l3_rst_n(l3_rst_n),
      .busy(busy), .result_valid(result_valid), .timeout_err(timeout_err),
      .cycle_count(cycle_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      int st;
      int len;
      int cc;
   } exp_t;

   exp_t q[$];
   int checks = 0;
   int errors = 0;

   int cfg_pl = 0, cfg_p1 = NEVER, cfg_p2 = NEVER, cfg_p3 = NEVER;
   bit stale2 = 1'b0;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic push(input int st, input int len, input int cc);
      exp_t e;
      e.st = st; e.len = len; e.cc = cc;
      q.push_back(e);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_state(input int s, input int budget);
      int n;
      n = 0;
      while (int'(state) != s && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (int'(state) != s) begin
         checks++;
         errors++;
         $display("FAIL wait_state: got state %0d, expected %0d within %0d cycles", state, s, budget);
      end
   endtask

   // Layer/loader models: done rises at the configured phase and stays high in that state.
   logic [2:0] dprev = 3'd0;
   int dphase = 0;
   always @(negedge clk) begin
      if (state !== dprev) dphase = 0;
      else                 dphase++;
      dprev = state;
      load_done = (state == 3'd1) && (dphase >= cfg_pl);
      l1_done   = (state == 3'd2) && (dphase >= cfg_p1);
      l2_done   = stale2 ? 1'b1 : ((state == 3'd3) && (dphase >= cfg_p2));
      l3_done   = (state == 3'd4) && (dphase >= cfg_p3);
   end

   logic [2:0] mprev = 3'd0;
   int mphase = 0;
   always @(negedge clk) begin
      exp_t e;
      if (state !== mprev) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_transition: got state %0d from %0d, expected none", state, mprev);
         end else begin
            e = q.pop_front();
            chk("entry_state", int'(state), e.st);
            if (e.len >= 0) chk("prev_state_len", mphase + 1, e.len);
            if (e.cc >= 0)  chk("entry_cycle_count", int'(cycle_count), e.cc);
         end
         mphase = 0;
      end else begin
         mphase++;
      end
      mprev = state;
      chk("busy", int'(busy), int'(state >= 3'd1 && state <= 3'd4));
      chk("result_valid", int'(result_valid), int'(state == 3'd5));
      chk("timeout_err", int'(timeout_err), int'(state == 3'd6));
      chk("l1_rst_n", int'(l1_rst_n), int'(state == 3'd2 && mphase >= 1));
      chk("l2_rst_n", int'(l2_rst_n), int'(state == 3'd3 && mphase >= 1));
      chk("l3_rst_n", int'(l3_rst_n), int'(state == 3'd4 && mphase >= 1));
   end

   initial begin
      #1 rst_n = 1'b0;
      #11;
      chk("rst_state", int'(state), 0);
      chk("rst_l1_rst_n", int'(l1_rst_n), 0);
      chk("rst_l2_rst_n", int'(l2_rst_n), 0);
      chk("rst_l3_rst_n", int'(l3_rst_n), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_result_valid", int'(result_valid), 0);
      chk("rst_timeout_err", int'(timeout_err), 0);
      chk("rst_cycle_count", int'(cycle_count), 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // Full run: 10 + 102 + 200 + 52 = 364 busy cycles.
      cfg_pl = 9; cfg_p1 = 101; cfg_p2 = 199; cfg_p3 = 51;
      push(1, -1, 0); push(2, 10, -1); push(3, 102, -1); push(4, 200, -1); push(5, 52, 364);
      pulse_start();
      wait_state(5, 1000);
      chk("full_cycle_count", int'(cycle_count), 364);
      chk("full_result_valid", int'(result_valid), 1);
      chk("full_busy", int'(busy), 0);
      repeat (2) @(negedge clk);

      // Stale l2_done: LAYER_2 must still last the 3-cycle minimum.
      cfg_pl = 0; cfg_p1 = 2; cfg_p2 = NEVER; cfg_p3 = 2; stale2 = 1'b1;
      push(1, -1, 0); push(2, 1, -1); push(3, 3, -1); push(4, 3, -1); push(5, 3, 10);
      pulse_start();
      wait_state(5, 100);
      stale2 = 1'b0;
      chk("stale_cycle_count", int'(cycle_count), 10);
      repeat (2) @(negedge clk);

      // Watchdog in LAYER_3, then restart clears cycle_count.
      cfg_pl = 0; cfg_p1 = 2; cfg_p2 = 2; cfg_p3 = NEVER;
      push(1, -1, 0); push(2, 1, -1); push(3, 3, -1); push(4, 3, -1); push(6, T, 307);
      pulse_start();
      wait_state(6, 1000);
      chk("wd_timeout_err", int'(timeout_err), 1);
      chk("wd_l3_rst_n", int'(l3_rst_n), 0);
      chk("wd_cycle_count", int'(cycle_count), 307);
      repeat (4) @(negedge clk);
      chk("wd_count_hold", int'(cycle_count), 307);
      cfg_p3 = 2;
      push(1, -1, 0); push(2, 1, -1); push(3, 3, -1); push(4, 3, -1); push(5, 3, 10);
      pulse_start();
      chk("restart_count", int'(cycle_count), 0);
      wait_state(5, 100);
      repeat (2) @(negedge clk);

      // Abort at LAYER_2 phase 50.
      cfg_pl = 0; cfg_p1 = 2; cfg_p2 = NEVER; cfg_p3 = 2;
      push(1, -1, 0); push(2, 1, -1); push(3, 3, -1); push(0, 51, 55);
      pulse_start();
      wait_state(3, 100);
      repeat (50) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_state", int'(state), 0);
      repeat (5) @(negedge clk);
      chk("abort_count_frozen", int'(cycle_count), 55);

      // abort together with start from DONE goes to IDLE and keeps the count.
      cfg_p2 = 2;
      push(1, -1, 0); push(2, 1, -1); push(3, 3, -1); push(4, 3, -1); push(5, 3, 10); push(0, -1, 10);
      pulse_start();
      wait_state(5, 100);
      repeat (2) @(negedge clk);
      abort = 1'b1; start = 1'b1;
      @(negedge clk);
      abort = 1'b0; start = 1'b0;
      chk("abort_start_state", int'(state), 0);
      repeat (3) @(negedge clk);
      chk("abort_start_hold", int'(state), 0);
      chk("abort_start_count", int'(cycle_count), 10);

      // Done at the watchdog-limit phase advances; start in LAYER_1 is ignored.
      cfg_pl = 0; cfg_p1 = T - 1; cfg_p2 = 2; cfg_p3 = 2;
      push(1, -1, 0); push(2, 1, -1); push(3, T, -1); push(4, 3, -1); push(5, 3, 1 + T + 6);
      pulse_start();
      wait_state(2, 100);
      repeat (5) @(negedge clk);
      start = 1'b1;
      repeat (3) @(negedge clk);
      start = 1'b0;
      wait_state(5, 1000);
      chk("boundary_timeout_err", int'(timeout_err), 0);
      repeat (2) @(negedge clk);

      // Asynchronous reset mid-LAYER_2 takes effect before the next edge.
      cfg_pl = 0; cfg_p1 = 2; cfg_p2 = NEVER; cfg_p3 = 2;
      push(1, -1, 0); push(2, 1, -1); push(3, 3, -1); push(0, -1, 0);
      pulse_start();
      wait_state(3, 100);
      repeat (10) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_state", int'(state), 0);
      chk("async_rst_l2_rst_n", int'(l2_rst_n), 0);
      chk("async_rst_busy", int'(busy), 0);
      chk("async_rst_count", int'(cycle_count), 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      chk("scoreboard_empty", q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got no completion, expected finish before %0t", $time);
      $fatal(1, "bench timeout");
   end

endmodule
